npc_exec_ctrl: RTL and testbench
================================

Name: npc_exec_ctrl

Overview:
Multi-cycle sequencer for the single-cycle NPC datapath: fetch, execute, register writeback, PC update.
- Fetches each instruction over a request/response memory handshake and holds it stable while the datapath evaluates.
- Pulses the register-file write enable for exactly one cycle per instruction, then commits the datapath's next_pc.
- Sits between instruction memory and the datapath top; also handles halt on ebreak and fault reporting.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset
TIMEOUT, 255, max cycles in WAIT before a fetch-timeout fault (1..255)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
run  in  1  enable; sampled in IDLE and at end of EXEC
ifu_req  out  1  fetch request valid
ifu_addr  out  32  fetch address, equals pc
ifu_ready  in  1  memory accepts request this cycle
ifu_rvalid  in  1  fetch data valid
ifu_rdata  in  32  fetched instruction
inst  out  32  latched instruction to datapath
pc  out  32  current PC to datapath
next_pc  in  32  datapath-computed next PC
wen  out  1  register-file write enable
halt  out  1  sticky, ebreak retired
fault  out  1  sticky, fault occurred
fault_cause  out  2  01 fetch timeout, 10 misaligned next_pc, 00 none
retired  out  32  retired-instruction counter

Behaviour:
- Reset: synchronous, active-high, overrides everything, including mid-fetch.
  - Reset values: state=IDLE, pc=RESET_PC, inst=32'h0000_0013 (nop), ifu_req=0, wen=0, halt=0, fault=0, fault_cause=00, retired=0, timer=0.
  - A response arriving after reset is ignored; IDLE never samples ifu_rvalid.
- States: IDLE, REQ, WAIT, EXEC, HALT, FAULT.
- IDLE:
  - Outputs: ifu_req=0, wen=0.
  - run=1 -> REQ next cycle.
- REQ:
  - Outputs: ifu_req=1, ifu_addr=pc; both held stable until ifu_ready.
  - ifu_ready=1 with ifu_rvalid=1 (zero-latency): latch inst=ifu_rdata, go to EXEC.
  - ifu_ready=1 alone: go to WAIT, clear timer.
- WAIT:
  - Outputs: ifu_req=0; timer increments each cycle.
  - ifu_rvalid=1: latch inst=ifu_rdata, go to EXEC. rvalid has priority over timeout in the same cycle.
  - timer==TIMEOUT without rvalid: go to FAULT, fault_cause=01.
- EXEC (exactly one cycle):
  - wen=1 combinationally from state, except when inst==32'h0010_0073 (ebreak) or next_pc[1:0]!=0; then wen=0.
  - ebreak: go to HALT; pc unchanged; retired+1.
  - next_pc misaligned: go to FAULT, fault_cause=10; pc unchanged; retired unchanged.
  - Otherwise: pc<=next_pc, retired+1 (wraps 2^32-1 -> 0), then run=1 -> REQ, run=0 -> IDLE.
- HALT / FAULT:
  - Terminal until rst.
  - Outputs: ifu_req=0, wen=0; pc, inst and retired frozen.
  - halt=1 in HALT; fault=1 in FAULT, fault_cause held.
- Latency and ordering:
  - Minimum 2 cycles per instruction (REQ with zero-latency response, then EXEC).
  - inst and pc are stable throughout EXEC.
  - wen never asserts outside EXEC.
- run deasserted during REQ/WAIT does not abort the fetch; it is re-sampled only at the end of EXEC.

Decomposition:
- Package npc_ctrl_pkg holds:
  - state enum
  - constants INST_EBREAK=32'h0010_0073, INST_NOP=32'h0000_0013
  - fault codes FAULT_NONE/FAULT_TIMEOUT/FAULT_MISALIGN
- One sub-module, ctrl_timeout_cnt: 8-bit counter with clear, enable, and a hit output compared to TIMEOUT.

Test Plan:
- Reset then run=1, memory ready=1, rvalid one cycle later, rdata=32'h0010_0093 (addi x1,x0,1), next_pc=32'h8000_0004 -> ifu_addr=32'h8000_0000, single-cycle wen pulse, pc becomes 32'h8000_0004, retired=1.
- ifu_ready held 0 for 3 cycles -> ifu_req=1 and ifu_addr stable all 3 cycles; accept on 4th; no wen before rvalid.
- No rvalid for 255 cycles in WAIT -> fault=1, fault_cause=01, wen never asserted, pc unchanged.
- Fetch of 32'h0010_0073 -> halt=1, wen=0 in EXEC, pc=32'h8000_0000, retired=1; later rvalid pulses ignored.
- next_pc=32'h8000_0006 -> fault_cause=10, wen=0, pc stays; rst asserted during a subsequent WAIT -> all outputs return to reset values next cycle, late rvalid ignored.
- Zero-latency ready+rvalid in REQ with run=1 continuously -> one instruction retired every 2 cycles; retired preloaded to 32'hFFFF_FFFF wraps to 0.

Source files
------------

// File: rtl/npc_ctrl_pkg.sv
// npc_ctrl_pkg: shared states, instruction constants and fault codes for the NPC sequencer
package npc_ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_EXEC, S_HALT, S_FAULT} state_e;
  localparam logic [31:0] INST_EBREAK    = 32'h0010_0073;
  localparam logic [31:0] INST_NOP       = 32'h0000_0013;
  localparam logic [1:0]  FAULT_NONE     = 2'b00;
  localparam logic [1:0]  FAULT_TIMEOUT  = 2'b01;
  localparam logic [1:0]  FAULT_MISALIGN = 2'b10;
endpackage

// File: rtl/ctrl_timeout_cnt.sv
// ctrl_timeout_cnt: counts WAIT cycles and flags when the count reaches TIMEOUT
module ctrl_timeout_cnt #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);
  logic [7:0] cnt_q, cnt_d;
  assign cnt_d = clr_i ? 8'd0 : en_i ? cnt_q + 8'd1 : cnt_q;
  assign hit_o = cnt_q == TIMEOUT;
  always_ff @(posedge clk)
    cnt_q <= rst ? 8'd0 : cnt_d;
endmodule

// File: rtl/npc_exec_ctrl.sv
// npc_exec_ctrl: multi-cycle fetch/execute/writeback sequencer for the NPC datapath
module npc_exec_ctrl
  import npc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h8000_0000,
  parameter int unsigned TIMEOUT       = 255,
  parameter logic [31:0] RESET_RETIRED = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        ifu_req,
  output logic [31:0] ifu_addr,
  input  logic        ifu_ready,
  input  logic        ifu_rvalid,
  input  logic [31:0] ifu_rdata,
  output logic [31:0] inst,
  output logic [31:0] pc,
  input  logic [31:0] next_pc,
  output logic        wen,
  output logic        halt,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] retired
);
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, inst_q, inst_d, retired_q, retired_d;
  logic [1:0]  cause_q, cause_d;
  logic        clr, en, hit, is_ebreak, misalign;
  ctrl_timeout_cnt #(.TIMEOUT(8'(TIMEOUT))) u_timeout (
    .clk,
    .rst,
    .clr_i(clr),
    .en_i (en),
    .hit_o(hit)
  );
  assign is_ebreak   = inst_q == INST_EBREAK;
  assign misalign    = next_pc[1:0] != 2'b00;
  assign ifu_req     = state_q == S_REQ;
  assign ifu_addr    = pc_q;
  assign inst        = inst_q;
  assign pc          = pc_q;
  assign wen         = state_q == S_EXEC && !is_ebreak && !misalign;
  assign halt        = state_q == S_HALT;
  assign fault       = state_q == S_FAULT;
  assign fault_cause = cause_q;
  assign retired     = retired_q;
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    retired_d = retired_q;
    cause_d   = cause_q;
    clr       = 1'b0;
    en        = 1'b0;
    case (state_q)
      S_IDLE: state_d = run ? S_REQ : S_IDLE;
      S_REQ: if (ifu_ready) begin
        clr     = 1'b1;
        state_d = ifu_rvalid ? S_EXEC : S_WAIT;
        inst_d  = ifu_rvalid ? ifu_rdata : inst_q;
      end
      S_WAIT: begin
        en = 1'b1;
        // a response landing on the timeout cycle still wins
        if (ifu_rvalid) begin
          inst_d  = ifu_rdata;
          state_d = S_EXEC;
        end else if (hit) begin
          state_d = S_FAULT;
          cause_d = FAULT_TIMEOUT;
        end
      end
      S_EXEC: if (is_ebreak) begin
        state_d   = S_HALT;
        retired_d = retired_q + 32'd1;
      end else if (misalign) begin
        state_d = S_FAULT;
        cause_d = FAULT_MISALIGN;
      end else begin
        pc_d      = next_pc;
        retired_d = retired_q + 32'd1;
        state_d   = run ? S_REQ : S_IDLE;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= INST_NOP;
      retired_q <= RESET_RETIRED;
      cause_q   <= FAULT_NONE;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      retired_q <= retired_d;
      cause_q   <= cause_d;
    end
  end
endmodule

// File: tb/tb_npc_exec_ctrl.sv
// tb_npc_exec_ctrl: scoreboarded random and directed bench for the NPC sequencer
module tb_npc_exec_ctrl;
  import npc_ctrl_pkg::*;
  localparam logic [31:0] RPC  = 32'h8000_0000;
  localparam logic [31:0] ADDI = 32'h0010_0093;
  localparam int TO = 255;
  typedef struct {logic [31:0] pc, inst, ret;} want_t;
  logic clk = 0, rst = 1, run = 0, ifu_ready = 0, ifu_rvalid = 0;
  logic [31:0] ifu_rdata = 0, next_pc = 0;
  logic ifu_req, wen, halt, fault;
  logic [31:0] ifu_addr, inst, pc, retired;
  logic [1:0] fault_cause;
  logic rst2 = 1;
  logic req2, wen2, halt2, fault2;
  logic [31:0] addr2, inst2, pc2, ret2, np2;
  logic [1:0] fc2;
  int checks = 0, errors = 0, cyc = 0, n2 = 0, last2 = 0;
  logic [31:0] want2 = 32'hFFFF_FFFE;
  logic [31:0] exp_pc, exp_ret;
  logic [1:0] exp_cause;
  logic exp_halt;
  want_t sb[$];
  want_t e;
  npc_exec_ctrl dut (
    .clk, .rst, .run, .ifu_req, .ifu_addr, .ifu_ready, .ifu_rvalid, .ifu_rdata,
    .inst, .pc, .next_pc, .wen, .halt, .fault, .fault_cause, .retired
  );
  assign np2 = pc2 + 32'd4;
  npc_exec_ctrl #(.RESET_RETIRED(32'hFFFF_FFFE)) dut2 (
    .clk, .rst(rst2), .run(1'b1), .ifu_req(req2), .ifu_addr(addr2), .ifu_ready(1'b1),
    .ifu_rvalid(1'b1), .ifu_rdata(ADDI), .inst(inst2), .pc(pc2), .next_pc(np2),
    .wen(wen2), .halt(halt2), .fault(fault2), .fault_cause(fc2), .retired(ret2)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, want);
    end
  endtask
  // every write-enable pulse must match the next retirement the model predicted
  always @(negedge clk) if (wen === 1'b1) begin
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_wen got pc %h want no pulse", pc);
    end else begin
      e = sb.pop_front();
      chk("wen_pc", pc, e.pc);
      chk("wen_inst", inst, e.inst);
      chk("wen_retired", retired, e.ret);
    end
  end
  always @(negedge clk) if (!rst2 && wen2 === 1'b1 && n2 < 8) begin
    chk("wrap_retired", ret2, want2);
    if (n2 > 0) chk("throughput_gap", cyc - last2, 2);
    last2 = cyc;
    want2 = want2 + 32'd1;
    n2++;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_reset();
    chk("rst_req", ifu_req, 0);
    chk("rst_wen", wen, 0);
    chk("rst_pc", pc, RPC);
    chk("rst_inst", inst, INST_NOP);
    chk("rst_halt", halt, 0);
    chk("rst_fault", fault, 0);
    chk("rst_cause", fault_cause, FAULT_NONE);
    chk("rst_retired", retired, 0);
  endtask
  task automatic do_reset();
    chk("sb_drained", sb.size(), 0);
    rst = 1; run = 0; ifu_ready = 0; ifu_rvalid = 0;
    tick();
    tick();
    rst = 0;
    exp_pc = RPC; exp_ret = 0; exp_halt = 0; exp_cause = FAULT_NONE;
    sb.delete();
  endtask
  task automatic fetch(logic [31:0] r, logic [31:0] npc, int rdly, int lat, bit run_after);
    int n;
    logic [31:0] a0;
    n = 0;
    while (!ifu_req && n < 64) begin
      tick();
      n++;
    end
    chk("req_seen", ifu_req, 1);
    chk("req_addr", ifu_addr, exp_pc);
    a0 = ifu_addr;
    for (int i = 0; i < rdly; i++) begin
      tick();
      chk("req_hold", ifu_req, 1);
      chk("addr_hold", ifu_addr, a0);
    end
    next_pc = npc;
    run = run_after;
    ifu_ready = 1;
    ifu_rvalid = lat == 0;
    ifu_rdata = r;
    if (r == INST_EBREAK) begin
      exp_ret = exp_ret + 1;
      exp_halt = 1;
    end else if (npc[1:0] != 2'b00) exp_cause = FAULT_MISALIGN;
    else begin
      sb.push_back('{exp_pc, r, exp_ret});
      exp_pc = npc;
      exp_ret = exp_ret + 1;
    end
    tick();
    ifu_ready = 0;
    ifu_rvalid = 0;
    if (lat > 0) begin
      for (int i = 1; i < lat; i++) begin
        tick();
        chk("wait_no_req", ifu_req, 0);
      end
      ifu_rvalid = 1;
      tick();
      ifu_rvalid = 0;
    end
    chk("exec_inst", inst, r);
    chk("exec_pc", pc, a0);
    tick();
    chk("pc_after", pc, exp_pc);
    chk("retired_after", retired, exp_ret);
    chk("halt_after", halt, exp_halt);
    chk("fault_after", fault, exp_cause != FAULT_NONE);
    chk("cause_after", fault_cause, exp_cause);
    if (!run_after && !exp_halt && exp_cause == FAULT_NONE) begin
      repeat (2) begin
        chk("idle_no_req", ifu_req, 0);
        tick();
      end
      run = 1;
    end
  endtask
  initial begin
    int k;
    logic [31:0] r, npc;
    tick();
    rst2 = 0;
    do_reset();
    chk_reset();
    run = 1;
    fetch(ADDI, 32'h8000_0004, 0, 1, 1);
    fetch(32'h0020_0113, 32'h8000_0008, 3, 2, 1);
    fetch(32'h0030_0193, 32'h8000_0010, 0, TO + 1, 1);
    do_reset();
    run = 1;
    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      if (r == INST_EBREAK) r = INST_NOP;
      npc = $urandom;
      npc[1:0] = 2'b00;
      fetch(r, npc, $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3) != 0);
    end
    do_reset();
    run = 1;
    tick();
    chk("to_req", ifu_req, 1);
    ifu_ready = 1;
    tick();
    ifu_ready = 0;
    k = 0;
    while (!fault && k < 400) begin
      tick();
      k++;
    end
    chk("timeout_cycles", k, TO + 1);
    chk("timeout_cause", fault_cause, FAULT_TIMEOUT);
    chk("timeout_pc", pc, RPC);
    chk("timeout_retired", retired, 0);
    do_reset();
    run = 1;
    fetch(INST_EBREAK, 32'h8000_0004, 0, 2, 1);
    repeat (3) begin
      ifu_rvalid = 1;
      ifu_rdata = ADDI;
      tick();
      ifu_rvalid = 0;
      tick();
    end
    chk("halt_sticky", halt, 1);
    chk("halt_inst", inst, INST_EBREAK);
    chk("halt_pc", pc, RPC);
    chk("halt_retired", retired, 1);
    chk("halt_no_req", ifu_req, 0);
    do_reset();
    run = 1;
    fetch(ADDI, 32'h8000_0004, 0, 0, 1);
    fetch(ADDI, 32'h8000_0006, 1, 1, 1);
    repeat (3) tick();
    chk("mis_fault", fault, 1);
    chk("mis_cause", fault_cause, FAULT_MISALIGN);
    chk("mis_pc", pc, 32'h8000_0004);
    chk("mis_retired", retired, 1);
    do_reset();
    run = 1;
    tick();
    ifu_ready = 1;
    tick();
    ifu_ready = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    run = 0;
    chk_reset();
    ifu_rvalid = 1;
    ifu_rdata = ADDI;
    tick();
    ifu_rvalid = 0;
    tick();
    chk("late_inst", inst, INST_NOP);
    chk("late_req", ifu_req, 0);
    chk("late_pc", pc, RPC);
    chk("wrap_events", n2, 8);
    chk("dut2_addr", addr2, pc2);
    chk("dut2_inst", inst2, ADDI);
    chk("dut2_status", {halt2, fault2, fc2, req2 | ~req2}, 5'b00001);
    chk("sb_final", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
